// File: rtl/cpu_core_param_if.sv
// cpu_core_param_if
//   Command/data/result bundle between a command source and cpu_core_param.
//   master : drives cmd_in, cmd_valid, din; observes cpu_rdy, done, out_reg3, zero, error
//   slave  : the core side (mirror of master)
//   cmd_in fields: [1:0] kind, [5:2] opcode, [5+SEL_W:6] sel_a, [5+2*SEL_W:6+SEL_W] sel_b
//   din: NUM_IN packed channels, channel k = din[k*WIDTH +: WIDTH]
interface cpu_core_param_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [5+2*SEL_W:0]      cmd_in;
  logic                    cmd_valid;
  logic                    cpu_rdy;
  logic [NUM_IN*WIDTH-1:0] din;
  logic                    done;
  logic [2*WIDTH-1:0]      out_reg3;
  logic                    zero;
  logic                    error;

  modport master (
    output cmd_in, cmd_valid, din,
    input  cpu_rdy, done, out_reg3, zero, error
  );

  modport slave (
    input  cmd_in, cmd_valid, din,
    output cpu_rdy, done, out_reg3, zero, error
  );
endinterface

// File: rtl/cpu_core_param.sv
// cpu_core_param
//   Parametrised CPU core: picks two operands from NUM_IN input channels and runs
//   one ALU or memory command per handshake through an IDLE/LOAD/EXEC/(RDWAIT)/DONE FSM.
//   Ports:
//     clk   - single clock, rising edge
//     reset - asynchronous, active-high; returns FSM to IDLE and clears all outputs
//     bus   - cpu_core_param_if.slave: cmd_in/cmd_valid/cpu_rdy handshake, din channels,
//             done pulse, out_reg3 (2*WIDTH) result, registered zero/error flags
//   Optional feature macro: CPU_ACC_EN
//     defined   : kind 11 is an accumulate ALU op (B taken from out_reg3[WIDTH-1:0])
//     undefined : kind 11 is a NOP that still walks LOAD->EXEC->DONE and pulses done
module cpu_core_param #(
  parameter int WIDTH     = 8,
  parameter int NUM_IN    = 4,
  parameter int MEM_DEPTH = 256
) (
  input  logic            clk,
  input  logic            reset,
  cpu_core_param_if.slave bus
);
  localparam int SEL_W  = $clog2(NUM_IN);
  localparam int RW     = 2 * WIDTH;
  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam int CMD_W  = 6 + 2 * SEL_W;
  localparam logic [RW-1:0] RW_MOD = RW'(RW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_RDWAIT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    K_ALU       = 2'b00,
    K_MEM_WRITE = 2'b01,
    K_MEM_READ  = 2'b10,
    K_ACC       = 2'b11
  } kind_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_DIV = 4'd8,
    OP_MOD = 4'd9
  } op_t;

  state_t state_q, state_d;

  logic [CMD_W-1:0] cmd_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [RW-1:0]    out_q;
  logic             zero_q, error_q;
  logic [RW-1:0]    rd_q;
  logic [RW-1:0]    mem [MEM_DEPTH];

  kind_t            kind;
  op_t              op;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic [WIDTH-1:0] a_mux, b_mux;
  logic [ADDR_W-1:0] addr;
  logic [RW-1:0]    a_ext, b_ext, shamt, alu_res;
  logic             alu_err;
  logic             alu_we;

  assign kind  = kind_t'(cmd_q[1:0]);
  assign op    = op_t'(cmd_q[5:2]);
  assign sel_a = cmd_q[5+SEL_W:6];
  assign sel_b = cmd_q[5+2*SEL_W:6+SEL_W];
  assign addr  = a_q[ADDR_W-1:0];

`ifdef CPU_ACC_EN
  assign alu_we = (kind == K_ALU) || (kind == K_ACC);
`else
  assign alu_we = (kind == K_ALU);
`endif

  // Channel select; unselected/out-of-range selects read as zero.
  always_comb begin
    a_mux = '0;
    b_mux = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel_a == k[SEL_W-1:0]) a_mux = bus.din[k*WIDTH +: WIDTH];
      if (sel_b == k[SEL_W-1:0]) b_mux = bus.din[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    a_ext   = RW'(a_q);
    b_ext   = RW'(b_q);
    shamt   = b_ext % RW_MOD;
    alu_res = '0;
    alu_err = 1'b0;
    case (op)
      OP_ADD: alu_res = a_ext + b_ext;
      OP_SUB: alu_res = a_ext - b_ext;
      OP_MUL: alu_res = a_ext * b_ext;
      OP_AND: alu_res = a_ext & b_ext;
      OP_OR:  alu_res = a_ext | b_ext;
      OP_XOR: alu_res = a_ext ^ b_ext;
      OP_SHL: alu_res = a_ext << shamt;
      OP_SHR: alu_res = a_ext >> shamt;
      OP_DIV: begin
        if (b_q == '0) alu_err = 1'b1;
        else           alu_res = a_ext / b_ext;
      end
      OP_MOD: begin
        if (b_q == '0) alu_err = 1'b1;
        else           alu_res = a_ext % b_ext;
      end
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.cmd_valid) state_d = S_LOAD;
      S_LOAD:   state_d = S_EXEC;
      S_EXEC:   state_d = (kind == K_MEM_READ) ? S_RDWAIT : S_DONE;
      S_RDWAIT: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && bus.cmd_valid) cmd_q <= bus.cmd_in;
      if (state_q == S_LOAD) begin
        a_q <= a_mux;
`ifdef CPU_ACC_EN
        b_q <= (kind == K_ACC) ? out_q[WIDTH-1:0] : b_mux;
`else
        b_q <= b_mux;
`endif
      end
      if (state_q == S_EXEC && alu_we) begin
        out_q   <= alu_res;
        zero_q  <= (alu_res == '0);
        error_q <= alu_err;
      end
      if (state_q == S_RDWAIT) begin
        out_q   <= rd_q;
        zero_q  <= (rd_q == '0);
        error_q <= 1'b0;
      end
    end
  end

  // Memory array is deliberately unreset; the read is registered so data is
  // available one cycle after EXEC, which is why reads need the RDWAIT state.
  always_ff @(posedge clk) begin
    if (state_q == S_EXEC && kind == K_MEM_WRITE) mem[addr] <= out_q;
    if (state_q == S_EXEC) rd_q <= mem[addr];
  end

  assign bus.cpu_rdy  = (state_q == S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.out_reg3 = out_q;
  assign bus.zero     = zero_q;
  assign bus.error    = error_q;
endmodule

// File: tb/tb_cpu_core_param.sv
module tb_cpu_core_param;
  localparam int WIDTH     = 8;
  localparam int NUM_IN    = 4;
  localparam int MEM_DEPTH = 256;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  cpu_core_param_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) bus ();

  cpu_core_param #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] out;
    logic        z;
    logic        e;
    logic [31:0] cyc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] mk(input logic [1:0] kind, input logic [3:0] op,
                                    input logic [1:0] sa, input logic [1:0] sb);
    return {sb, sa, op, kind};
  endfunction

  function automatic logic [31:0] pk(input logic [7:0] c0, input logic [7:0] c1,
                                     input logic [7:0] c2, input logic [7:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  // Wait for cpu_rdy, present the command, and on acceptance push the expected
  // result with the cycle at which done must be seen (accept cycle + lat).
  task automatic send(input string nm, input logic [9:0] cmd, input logic [31:0] d,
                      input bit push, input logic [15:0] eo, input logic ez, input logic ee,
                      input int unsigned lat, input bit hold, output int unsigned acc);
    int unsigned budget;
    budget = 0;
    acc = 0;
    @(negedge clk);
    while (!bus.cpu_rdy && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.cpu_rdy) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s rdy_timeout: got cpu_rdy=0 after %0d cycles expected cpu_rdy=1", nm, budget);
      bus.cmd_valid = 1'b0;
      return;
    end
    bus.cmd_in    = cmd;
    bus.din       = d;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    if (push) begin
      exp_q.push_back('{eo, ez, ee, cyc + lat});
      name_q.push_back(nm);
    end
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk({nm, " out_reg3"}, 32'(bus.out_reg3), 32'(e.out));
        chk({nm, " zero"}, 32'(bus.zero), 32'(e.z));
        chk({nm, " error"}, 32'(bus.error), 32'(e.e));
        chk({nm, " done_cycle"}, cyc, e.cyc);
      end
    end
  end

  initial begin
    int unsigned a0, a1, b;
    bus.cmd_in    = '0;
    bus.cmd_valid = 1'b0;
    bus.din       = '0;
    reset         = 1'b1;

    #2;
    chk("rst cpu_rdy", 32'(bus.cpu_rdy), 32'd1);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst out_reg3", 32'(bus.out_reg3), 32'd0);
    chk("rst zero", 32'(bus.zero), 32'd0);
    chk("rst error", 32'(bus.error), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst cpu_rdy", 32'(bus.cpu_rdy), 32'd1);

    // ALU and memory sequence
    send("add",   mk(2'd0, 4'd0, 2'd1, 2'd2), pk(8'd0, 8'd200, 8'd100, 8'd0), 1, 16'h012C, 0, 0, 2, 0, a0);
    send("memwr", mk(2'd1, 4'd0, 2'd0, 2'd0), pk(8'h10, 8'd0, 8'd0, 8'd0),    1, 16'h012C, 0, 0, 2, 0, a0);
    send("and0",  mk(2'd0, 4'd3, 2'd0, 2'd1), pk(8'h0F, 8'hF0, 8'd0, 8'd0),   1, 16'h0000, 1, 0, 2, 0, a0);
    send("memrd", mk(2'd2, 4'd0, 2'd0, 2'd0), pk(8'h10, 8'd0, 8'd0, 8'd0),    1, 16'h012C, 0, 0, 3, 0, a0);
    send("sub0",  mk(2'd0, 4'd1, 2'd0, 2'd3), pk(8'd5, 8'd0, 8'd0, 8'd5),     1, 16'h0000, 1, 0, 2, 0, a0);
    send("div0",  mk(2'd0, 4'd8, 2'd0, 2'd1), pk(8'd7, 8'd0, 8'd0, 8'd0),     1, 16'h0000, 1, 1, 2, 0, a0);
    send("op12",  mk(2'd0, 4'd12, 2'd0, 2'd1), pk(8'd3, 8'd4, 8'd0, 8'd0),    1, 16'h0000, 1, 1, 2, 0, a0);
    send("subw",  mk(2'd0, 4'd1, 2'd0, 2'd1), pk(8'd3, 8'd5, 8'd0, 8'd0),     1, 16'hFFFE, 0, 0, 2, 0, a0);
    send("shl",   mk(2'd0, 4'd6, 2'd2, 2'd3), pk(8'd0, 8'd0, 8'h81, 8'd17),   1, 16'h0102, 0, 0, 2, 0, a0);
    send("shr",   mk(2'd0, 4'd7, 2'd0, 2'd1), pk(8'hF0, 8'd4, 8'd0, 8'd0),    1, 16'h000F, 0, 0, 2, 0, a0);
    send("div",   mk(2'd0, 4'd8, 2'd1, 2'd0), pk(8'd7, 8'd200, 8'd0, 8'd0),   1, 16'h001C, 0, 0, 2, 0, a0);
    send("mod",   mk(2'd0, 4'd9, 2'd1, 2'd0), pk(8'd7, 8'd200, 8'd0, 8'd0),   1, 16'h0004, 0, 0, 2, 0, a0);
    send("or",    mk(2'd0, 4'd4, 2'd0, 2'd1), pk(8'h0A, 8'h50, 8'd0, 8'd0),   1, 16'h005A, 0, 0, 2, 0, a0);
    send("xor",   mk(2'd0, 4'd5, 2'd3, 2'd2), pk(8'd0, 8'd0, 8'h0F, 8'hFF),   1, 16'h00F0, 0, 0, 2, 0, a0);

    // cmd_valid held through the busy period with a different command on the bus
    send("hs_add", mk(2'd0, 4'd0, 2'd0, 2'd1), pk(8'd9, 8'd4, 8'd0, 8'd0), 1, 16'h000D, 0, 0, 2, 1, a0);
    bus.cmd_in = mk(2'd0, 4'd1, 2'd0, 2'd1);
    send("hs_sub", mk(2'd0, 4'd1, 2'd0, 2'd1), pk(8'd9, 8'd4, 8'd0, 8'd0), 1, 16'h0005, 0, 0, 2, 0, a1);
    chk("hs accept_gap", a1 - a0, 32'd4);

    // reset during EXEC of MUL: no done, outputs cleared
    send("mul_abort", mk(2'd0, 4'd2, 2'd2, 2'd3), pk(8'd0, 8'd0, 8'd255, 8'd255), 0, 16'h0, 0, 0, 2, 0, a0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst out_reg3", 32'(bus.out_reg3), 32'd0);
    chk("mid_rst cpu_rdy", 32'(bus.cpu_rdy), 32'd1);
    chk("mid_rst done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("after_rst cpu_rdy", 32'(bus.cpu_rdy), 32'd1);
    chk("after_rst out_reg3", 32'(bus.out_reg3), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("after_rst out_hold", 32'(bus.out_reg3), 32'd0);
    send("mul", mk(2'd0, 4'd2, 2'd2, 2'd3), pk(8'd0, 8'd0, 8'd255, 8'd255), 1, 16'hFE01, 0, 0, 2, 0, a0);

    // accumulate / NOP on kind 11
    send("add7", mk(2'd0, 4'd0, 2'd0, 2'd1), pk(8'd3, 8'd4, 8'd0, 8'd0), 1, 16'h0007, 0, 0, 2, 0, a0);
`ifdef CPU_ACC_EN
    send("acc", mk(2'd3, 4'd0, 2'd0, 2'd3), pk(8'd10, 8'd0, 8'd0, 8'd99), 1, 16'h0011, 0, 0, 2, 0, a0);
`else
    send("nop", mk(2'd3, 4'd0, 2'd0, 2'd3), pk(8'd10, 8'd0, 8'd0, 8'd99), 1, 16'h0007, 0, 0, 2, 0, a0);
`endif

    b = 0;
    while (exp_q.size() != 0 && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d outstanding done pulses expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
